// File: rtl/sad_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sad_pkg                                                                  |
// | Shared types and helpers for the SAD mask loader and datapath.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package sad_pkg;

  localparam int MAX_MASK_SIZE = 15;

  typedef enum logic [1:0] {
    LOAD_L = 2'd0,
    LOAD_R = 2'd1,
    RESULT = 2'd2
  } sad_state_t;

  // Smallest result width that holds mask_size^2 * (2^pix_w - 1) without wrap.
  function automatic int sad_sum_width(input int mask_size, input int pix_w);
    longint max_sum;
    max_sum = longint'(mask_size) * longint'(mask_size) * ((longint'(1) << pix_w) - 1);
    return $clog2(max_sum + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sad_absdiff_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sad_absdiff_acc                                                          |
// | Combinational |a-b| feeding a registered accumulator with clear/enable.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sad_absdiff_acc #(
  parameter int PIX_W = 8,
  parameter int SUM_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [PIX_W-1:0] i_a,
  input  logic [PIX_W-1:0] i_b,
  output logic [SUM_W-1:0] o_sum_next,
  output logic [SUM_W-1:0] o_acc
);

  logic [PIX_W-1:0] w_diff;
  logic [SUM_W-1:0] w_diff_ext;
  logic [SUM_W-1:0] r_acc;

  assign w_diff     = (i_a > i_b) ? (i_a - i_b) : (i_b - i_a);
  assign w_diff_ext = SUM_W'(w_diff);
  assign o_sum_next = r_acc + w_diff_ext;
  assign o_acc      = r_acc;

  // Clear wins over enable so a phase change always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sad_mask_stream_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sad_mask_stream_loader                                                   |
// | Streams a left then right mask, accumulates SAD, presents the result.    |
// | Optional macro SAD_FRAME_CHECK_EN adds the sticky frame_err output.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sad_mask_stream_loader
  import sad_pkg::*;
#(
  parameter int MASK_SIZE = 3,
  parameter int PIX_W     = 8,
  parameter int SUM_W     = 12
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] res_data,
  output logic             busy
`ifdef SAD_FRAME_CHECK_EN
  ,
  output logic             frame_err
`endif
);

  localparam int                 N        = MASK_SIZE * MASK_SIZE;
  localparam int                 IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N - 1);

  sad_state_t       r_state;
  sad_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [PIX_W-1:0] r_left [N];
  logic             r_res_valid;
  logic [SUM_W-1:0] r_res_data;
  logic             r_busy;

  logic             w_xfer;
  logic             w_idx_last;
  logic             w_res_hs;
  logic             w_acc_clr;
  logic             w_acc_en;
  logic [SUM_W-1:0] w_sum_next;
  logic [SUM_W-1:0] w_acc;

  assign w_xfer     = pix_valid && pix_ready;
  assign w_idx_last = (r_idx == LAST_IDX);
  assign w_res_hs   = r_res_valid && res_ready;
  assign w_acc_clr  = w_xfer && (r_state == LOAD_L) && w_idx_last;
  assign w_acc_en   = w_xfer && (r_state == LOAD_R);

  // State register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= LOAD_L;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD_L:  if (w_xfer && w_idx_last) w_state_nxt = LOAD_R;
      LOAD_R:  if (w_xfer && w_idx_last) w_state_nxt = RESULT;
      RESULT:  if (w_res_hs)             w_state_nxt = LOAD_L;
      default:                           w_state_nxt = LOAD_L;
    endcase
  end

  // Outputs: pix_ready decodes the state register only, never the inputs.
  always_comb begin
    pix_ready = (r_state != RESULT);
    res_valid = r_res_valid;
    res_data  = r_res_data;
    busy      = r_busy;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_idx       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_idx <= w_idx_last ? '0 : (r_idx + 1'b1);
      end
      if (w_xfer && (r_state == LOAD_L)) begin
        r_busy <= 1'b1;
      end else if (w_res_hs) begin
        r_busy <= 1'b0;
      end
      if (w_acc_en && w_idx_last) begin
        r_res_valid <= 1'b1;
        r_res_data  <= w_sum_next;
      end else if (w_res_hs) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  // Left-mask store carries no reset; every entry is written before use.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_xfer && (r_state == LOAD_L)) begin
      r_left[r_idx] <= pix_data;
    end
  end

  sad_absdiff_acc #(
    .PIX_W (PIX_W),
    .SUM_W (SUM_W)
  ) u_acc (
    .clk        (S_AXI_ACLK),
    .rst_n      (S_AXI_ARESETN),
    .i_clr      (w_acc_clr),
    .i_en       (w_acc_en),
    .i_a        (pix_data),
    .i_b        (r_left[r_idx]),
    .o_sum_next (w_sum_next),
    .o_acc      (w_acc)
  );

`ifdef SAD_FRAME_CHECK_EN
  logic r_frame_err;
  logic w_last_beat;
  logic [SUM_W-1:0] w_unused_acc;

  assign w_last_beat  = (r_state == LOAD_R) && w_idx_last;
  assign w_unused_acc = w_acc;
  assign frame_err    = r_frame_err;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_frame_err <= 1'b0;
    end else if (w_xfer && (pix_last != w_last_beat)) begin
      r_frame_err <= 1'b1;
    end
  end
`else
  logic             w_unused_last;
  logic [SUM_W-1:0] w_unused_acc;

  assign w_unused_last = pix_last;
  assign w_unused_acc  = w_acc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sad_mask_stream_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sad_mask_stream_loader                                                |
// | Scoreboard bench: stimulus pushes model SADs, a monitor pops on handshake.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sad_mask_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid, pix_ready, pix_last;
  logic [7:0]  pix_data;
  logic        res_valid, res_ready, busy;
  logic [11:0] res_data;

  logic        p1_valid, p1_ready, p1_last, p1_res_valid, p1_busy;
  logic [7:0]  p1_data;
  logic [7:0]  p1_res_data;
`ifdef SAD_FRAME_CHECK_EN
  logic        frame_err, p1_frame_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int q[$];
  int rr_hold  = 0;
  bit rr_rand  = 0;

  always #5 clk = ~clk;

  sad_mask_stream_loader #(.MASK_SIZE(3), .PIX_W(8), .SUM_W(12)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .pix_last      (pix_last),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .busy          (busy)
`ifdef SAD_FRAME_CHECK_EN
    ,
    .frame_err     (frame_err)
`endif
  );

  sad_mask_stream_loader #(.MASK_SIZE(1), .PIX_W(8), .SUM_W(8)) dut1 (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .pix_valid     (p1_valid),
    .pix_ready     (p1_ready),
    .pix_data      (p1_data),
    .pix_last      (p1_last),
    .res_valid     (p1_res_valid),
    .res_ready     (1'b1),
    .res_data      (p1_res_data),
    .busy          (p1_busy)
`ifdef SAD_FRAME_CHECK_EN
    ,
    .frame_err     (p1_frame_err)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // res_ready driver: changes just after the rising edge.
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rr_hold > 0) begin
        res_ready = 1'b0;
        if (res_valid) rr_hold--;
      end else begin
        res_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic        prev_v, prev_r;
    logic [11:0] prev_d;
    int          e;
    prev_v = 0; prev_r = 0; prev_d = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (res_valid) begin
          chk("pix_ready_low_in_result", int'(pix_ready), 0);
          if (prev_v && !prev_r) chk("res_data_stable", int'(res_data), int'(prev_d));
          if (res_ready) begin
            if (q.size() == 0) begin
              chk("unexpected_result", int'(res_data), -1);
            end else begin
              e = q.pop_front();
              chk("res_data", int'(res_data), e);
            end
          end
        end
        prev_v = res_valid; prev_r = res_ready; prev_d = res_data;
      end else begin
        prev_v = 0;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send(input int d, input bit l);
    int w = 0;
    pix_valid = 1'b1; pix_data = 8'(d); pix_last = l;
    while (!pix_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!pix_ready) chk("pix_ready_timeout", 0, 1);
    @(negedge clk);
    pix_valid = 1'b0; pix_data = 8'($urandom); pix_last = 1'b0;
  endtask

  task automatic run_mask(input int l[9], input int r[9], input int gap_max,
                          input int bad, input int nbeats);
    int e = 0;
    for (int i = 0; i < 9; i++) e += (l[i] > r[i]) ? l[i] - r[i] : r[i] - l[i];
    if (nbeats == 18) q.push_back(e);
    for (int b = 0; b < nbeats; b++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send((b < 9) ? l[b] : r[b - 9], (b == 17) || (b == bad));
      if (b == 0) chk("busy_after_first", int'(busy), 1);
    end
    if (nbeats == 18) begin
      chk("latency_res_valid", int'(res_valid), 1);
      chk("pix_ready_after_last", int'(pix_ready), 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pix_ready", int'(pix_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_busy", int'(busy), 0);
`ifdef SAD_FRAME_CHECK_EN
    chk("rst_frame_err", int'(frame_err), 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int w = 0;
    while ((q.size() != 0 || res_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l[9], r[9];
    pix_valid = 0; pix_data = 0; pix_last = 0;
    p1_valid = 0; p1_data = 0; p1_last = 0;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed: 5s vs 1s, ready high -> 36, pix_ready low exactly one cycle.
    foreach (l[i]) begin l[i] = 5; r[i] = 1; end
    run_mask(l, r, 0, -1, 18);
    chk("res_data_36_direct", int'(res_data), 36);
    @(negedge clk);
    chk("pix_ready_back", int'(pix_ready), 1);
    chk("busy_clear", int'(busy), 0);
    chk("res_valid_clear", int'(res_valid), 0);

    foreach (l[i]) begin l[i] = i; r[i] = 8 - i; end
    run_mask(l, r, 0, -1, 18);
    foreach (l[i]) begin l[i] = 255; r[i] = 0; end
    run_mask(l, r, 0, -1, 18);
    chk("res_data_2295_direct", int'(res_data), 2295);

    // Back-pressure: result held 10 cycles; next mask queued behind it.
    foreach (l[i]) begin l[i] = $urandom_range(0, 255); r[i] = $urandom_range(0, 255); end
    run_mask(l, r, 3, -1, 18);
    rr_hold = 10;
    foreach (l[i]) begin l[i] = $urandom_range(0, 255); r[i] = $urandom_range(0, 255); end
    run_mask(l, r, 2, -1, 18);

    // Random masks with random gaps and random res_ready.
    rr_rand = 1;
    for (int k = 0; k < 20; k++) begin
      foreach (l[i]) begin l[i] = $urandom_range(0, 255); r[i] = $urandom_range(0, 255); end
      run_mask(l, r, 3, -1, 18);
    end
    rr_rand = 0;
    drain();

`ifdef SAD_FRAME_CHECK_EN
    chk("frame_err_clean", int'(frame_err), 0);
`endif

    // Reset after 12 beats: partial mask discarded, no result.
    foreach (l[i]) begin l[i] = 9; r[i] = 2; end
    run_mask(l, r, 1, -1, 12);
    @(negedge clk);
    do_reset();
    repeat (3) @(negedge clk);
    chk("no_res_after_reset", int'(res_valid), 0);
    foreach (l[i]) begin l[i] = 3; r[i] = 7; end
    run_mask(l, r, 0, -1, 18);
    chk("res_data_36_after_reset", int'(res_data), 36);
    drain();

`ifdef SAD_FRAME_CHECK_EN
    foreach (l[i]) begin l[i] = 4; r[i] = 6; end
    run_mask(l, r, 0, 16, 18);
    chk("frame_err_early_last", int'(frame_err), 1);
    drain();
`endif

    // MASK_SIZE 1 instance: 200 vs 10 -> 190 one cycle after the second beat.
    p1_valid = 1; p1_data = 8'd200; p1_last = 0;
    chk("m1_ready", int'(p1_ready), 1);
    @(negedge clk);
    p1_data = 8'd10; p1_last = 1;
    chk("m1_ready_r", int'(p1_ready), 1);
    @(negedge clk);
    p1_valid = 0; p1_last = 0;
    chk("m1_res_valid", int'(p1_res_valid), 1);
    chk("m1_res_data", int'(p1_res_data), 190);
    @(negedge clk);
    chk("m1_res_done", int'(p1_res_valid), 0);
`ifdef SAD_FRAME_CHECK_EN
    chk("m1_frame_err", int'(p1_frame_err), 0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
